// File: rtl/mbist_pkg.sv
// Shared types and March C- table for the MBIST controller.
package mbist_pkg;

    // Top-level sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int ELEM_W = 3;

    // March element indices.
    localparam logic [ELEM_W-1:0] M0 = 3'd0;
    localparam logic [ELEM_W-1:0] M1 = 3'd1;
    localparam logic [ELEM_W-1:0] M2 = 3'd2;
    localparam logic [ELEM_W-1:0] M3 = 3'd3;
    localparam logic [ELEM_W-1:0] M4 = 3'd4;
    localparam logic [ELEM_W-1:0] M5 = 3'd5;

    // March table, one bit per element (bit index = element index).
    // M0 up(w0) M1 up(r0,w1) M2 up(r1,w0) M3 down(r0,w1) M4 down(r1,w0) M5 up(r0)
    localparam logic [5:0] ELEM_DOWN   = 6'b011000;
    localparam logic [5:0] ELEM_TWO_OP = 6'b011110;
    localparam logic [5:0] ELEM_RVAL   = 6'b010100;
    localparam logic [5:0] ELEM_WVAL   = 6'b001010;

    // Memory operations per word over the whole algorithm.
    localparam int OPS_PER_WORD = 10;

    // Single-op elements: M0 is a write, M5 a read. Two-op elements read first.
    function automatic logic op_is_write(input logic [ELEM_W-1:0] elem, input logic op);
        if (elem == M0) return 1'b1;
        if (elem == M5) return 1'b0;
        return op;
    endfunction

endpackage

// File: rtl/mbist_cmp.sv
// Read-data checker: carries expected word/address/element alongside the
// two-cycle memory read latency and captures the first miscompare.
module mbist_cmp
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  rd_valid_i,
    input  logic [DATA_WIDTH-1:0] rd_exp_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [ELEM_W-1:0]     rd_elem_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic [ELEM_W-1:0]     fail_elem_o
);

    logic                  s1_valid_q, s2_valid_q;
    logic [DATA_WIDTH-1:0] s1_exp_q,   s2_exp_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q,  s2_addr_q;
    logic [ELEM_W-1:0]     s1_elem_q,  s2_elem_q;
    logic                  miscompare;

    // Stage 2 lines up with the cycle in which the memory presents the data.
    assign miscompare = s2_valid_q && (rdata_i != s2_exp_q);

    // Expected-data pipeline, matched to the memory read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_exp_q   <= '0;
            s1_addr_q  <= '0;
            s1_elem_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_exp_q   <= '0;
            s2_addr_q  <= '0;
            s2_elem_q  <= '0;
        end else begin
            s1_valid_q <= rd_valid_i;
            s1_exp_q   <= rd_exp_i;
            s1_addr_q  <= rd_addr_i;
            s1_elem_q  <= rd_elem_i;
            s2_valid_q <= s1_valid_q;
            s2_exp_q   <= s1_exp_q;
            s2_addr_q  <= s1_addr_q;
            s2_elem_q  <= s1_elem_q;
        end
    end

    // First-fail capture; sticky until a new test is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
            fail_elem_o <= '0;
        end else if (clear_i) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
            fail_elem_o <= '0;
        end else if (miscompare && !fail_o) begin
            fail_o      <= 1'b1;
            fail_addr_o <= s2_addr_q;
            fail_data_o <= rdata_i;
            fail_elem_o <= s2_elem_q;
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: walks element/op/address counters, drives the memory
// pins one op per cycle and hands every read to the compare pipeline.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic [ELEM_W-1:0]     fail_elem_o,
    output logic                  mem_write_read_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [ELEM_W-1:0]     elem_q, elem_d, elem_nx;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  drain_q, drain_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  start_acc, op_last, addr_term, is_write;

    // Sequencer registers; counters describe the op on the pins this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            elem_q  <= M0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            drain_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state and counter stepping through the March table.
    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        op_d      = op_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        start_acc = 1'b0;
        elem_nx   = elem_q + 3'd1;
        op_last   = ~ELEM_TWO_OP[elem_q] | op_q;
        addr_term = ELEM_DOWN[elem_q] ? (addr_q == '0) : (addr_q == ADDR_LAST);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_RUN;
                    start_acc = 1'b1;
                    elem_d    = M0;
                    op_d      = 1'b0;
                    addr_d    = '0;
                end
            end
            S_RUN: begin
                if (!op_last) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (!addr_term) begin
                        addr_d = ELEM_DOWN[elem_q] ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                    end else if (elem_q == M5) begin
                        // Park counters at the first op so the idle pins already
                        // present the next test's opening write data.
                        state_d = S_DRAIN;
                        elem_d  = M0;
                        addr_d  = '0;
                        drain_d = 1'b0;
                    end else begin
                        elem_d = elem_nx;
                        addr_d = ELEM_DOWN[elem_nx] ? ADDR_LAST : '0;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_DONE;
                    drain_d = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Writes always follow a read of the same element (or M0 follows
        // idle), so the element's write value one op early is the lookahead
        // the memory needs.
        wdata_d = {DATA_WIDTH{ELEM_WVAL[elem_d]}};
    end

    assign is_write         = op_is_write(elem_q, op_q);
    assign busy_o           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o           = (state_q == S_DONE);
    assign mem_write_read_o = (state_q == S_RUN) && is_write;
    assign mem_address_o    = addr_q;
    assign mem_wdata_o      = wdata_q;

    mbist_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (start_acc),
        .rd_valid_i  ((state_q == S_RUN) && !is_write),
        .rd_exp_i    ({DATA_WIDTH{ELEM_RVAL[elem_q]}}),
        .rd_addr_i   (addr_q),
        .rd_elem_i   (elem_q),
        .rdata_i     (mem_rdata_i),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_data_o (fail_data_o),
        .fail_elem_o (fail_elem_o)
    );

endmodule
